msu_sched: RTL and testbench
============================

Name: msu_sched

Overview:
- Time-sliced scheduler that shares one modular squaring core among NREQ requesters.
- Each requester submits a job: an initial value (Montgomery form) and an iteration count T.
- The block sequences repeated squarings through the core, preempts jobs round-robin every QUANTUM squarings, and returns each result tagged with its requester id.
- Sits between the host-facing stream logic and the squaring datapath.

Parameters:
- NREQ, 4, number of requesters/context slots (power of 2, >=2)
- DAT_BITS, 64, width of value passed to/from the core
- T_LEN, 64, width of iteration count
- QUANTUM, 1024, squarings per time slice before preemption (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_val  in  NREQ  per-slot job request valid
- req_rdy  out  NREQ  per-slot ready; high when slot free
- req_dat  in  NREQ*DAT_BITS  initial values, slot i at [i*DAT_BITS +: DAT_BITS]
- req_cnt  in  NREQ*T_LEN  iteration counts, slot i at [i*T_LEN +: T_LEN]
- core_in_val  out  1  operand valid to squaring core
- core_in_rdy  in  1  core accepts operand
- core_in_dat  out  DAT_BITS  operand
- core_out_val  in  1  core result valid
- core_out_rdy  out  1  scheduler accepts result
- core_out_dat  in  DAT_BITS  squared result
- rsp_val  out  1  completed job valid
- rsp_rdy  in  1  downstream accepts result
- rsp_dat  out  DAT_BITS  final value
- rsp_id  out  $clog2(NREQ)  slot of completed job
- busy  out  1  a squaring is outstanding in the core
- cur_id  out  $clog2(NREQ)  slot currently owning the core

Behaviour:
- Reset (async, rst_n=0): all slots free, done flags clear, rr pointers=0, FSM=IDLE.
- Output reset values: req_rdy={NREQ{1'b1}} once out of reset; core_in_val=0; core_out_rdy=0; rsp_val=0; rsp_dat=0; rsp_id=0; busy=0; cur_id=0.
- Core in-flight results are discarded; the core shares rst_n.
- Per-slot context: occ, done, val[DAT_BITS], rem[T_LEN].
- req_rdy[i]=~occ[i]. On req_val[i]&req_rdy[i]: occ<=1, val<=req_dat slice, rem<=req_cnt slice; done<=1 if cnt==0, else 0.
- A slot is runnable when occ & ~done & rem!=0.
- FSM states:
  - IDLE: if any slot runnable -> SELECT.
  - SELECT (1 cycle): pick first runnable slot at or after rr pointer (wrapping); cur_id<=slot; q_cnt<=0 -> ISSUE.
  - ISSUE: core_in_val=1, core_in_dat=val[cur_id]; on core_in_rdy -> WAIT, busy=1.
  - WAIT: core_out_rdy=1; on core_out_val: val[cur_id]<=core_out_dat, rem<=rem-1, q_cnt<=q_cnt+1, busy<=0.
    - If rem==1: done[cur_id]<=1, rr<=cur_id+1 -> IDLE.
    - Else if q_cnt==QUANTUM-1 and another slot runnable: rr<=cur_id+1 -> SELECT (preempt; context already in slot regs).
    - Else if q_cnt==QUANTUM-1 and no other slot runnable: q_cnt<=0 -> ISSUE (same job continues).
    - Else -> ISSUE.
- Min latency:
  - req handshake at cycle N -> SELECT at N+1, core_in_val at N+2.
  - Back-to-back squarings: ISSUE asserted the cycle after the core_out handshake.
- Response path, independent of compute FSM:
  - Round-robin over done slots with a separate pointer.
  - rsp_val registered; rsp_dat/rsp_id held stable while rsp_val & ~rsp_rdy.
  - On handshake: occ<=0, done<=0, pointer<=id+1.
  - req_rdy[id] rises the following cycle.
- cnt==0 job: no core traffic; rsp_val within 2 cycles of acceptance with rsp_dat=req_dat.
- Simultaneous new request plus preemption decision: the new slot is eligible only from the next SELECT evaluation if occ is already set; no same-cycle bypass.
- rem is never decremented below 0; count width wraps are impossible by construction.
- Slot free/occupied is the only flow control; the block never drops a request or response.

Test Plan:
- Core model = x^2 mod 1000003 with 3-cycle latency. Slot0 val=2, cnt=3 -> exactly 3 core_in handshakes; rsp_dat=256, rsp_id=0; req_rdy[0] returns high the cycle after the rsp handshake.
- Slot2 val=77, cnt=0 -> no core_in_val; rsp_val within 2 cycles with rsp_dat=77, rsp_id=2.
- QUANTUM=4; slot0 and slot1 both cnt=10, same cycle -> cur_id sequence 0,1,0,1,0,1 with slice lengths 4,4,4,4,2,2; both results match 10 sequential squarings of each input.
- QUANTUM=4; only slot3 active, cnt=9 -> no SELECT gaps beyond the first; 9 consecutive squarings on slot3.
- rsp_rdy=0 while slots 0 and 1 complete -> rsp_val held with id 0 stable; req_rdy[0], req_rdy[1] stay 0; releasing rsp_rdy returns id 0 then id 1.
- rst_n pulsed low during WAIT of a cnt=100 job -> all outputs immediately at reset values; after release req_rdy all 1 and no spurious rsp_val.

Source files
------------

// File: rtl/msu_sched.sv
// Time-sliced scheduler sharing one modular squaring core across NREQ job slots.
// Round-robin preemption every QUANTUM squarings; completed jobs drain on a separate round-robin.
module msu_sched #(
    parameter int NREQ     = 4,
    parameter int DAT_BITS = 64,
    parameter int T_LEN    = 64,
    parameter int QUANTUM  = 1024,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_val,
    output logic [NREQ-1:0]          req_rdy,
    input  logic [NREQ*DAT_BITS-1:0] req_dat,
    input  logic [NREQ*T_LEN-1:0]    req_cnt,
    output logic                     core_in_val,
    input  logic                     core_in_rdy,
    output logic [DAT_BITS-1:0]      core_in_dat,
    input  logic                     core_out_val,
    output logic                     core_out_rdy,
    input  logic [DAT_BITS-1:0]      core_out_dat,
    output logic                     rsp_val,
    input  logic                     rsp_rdy,
    output logic [DAT_BITS-1:0]      rsp_dat,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy,
    output logic [IDW-1:0]           cur_id
);
    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QUANTUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      cur_q, cur_d, rr_q, rr_d;
    logic [QW-1:0]       q_cnt_q, q_cnt_d;
    logic                busy_q, busy_d;

    logic [NREQ-1:0]     occ_q, done_q;
    logic [DAT_BITS-1:0] val_q [NREQ];
    logic [T_LEN-1:0]    rem_q [NREQ];

    logic                rsp_val_q;
    logic [DAT_BITS-1:0] rsp_dat_q;
    logic [IDW-1:0]      rsp_id_q, rsp_ptr_q;

    logic [NREQ-1:0]     req_acc, acc_nz, runnable, others, drainable;
    logic [IDW-1:0]      sel_idx, sel_id, rsp_idx, rsp_sel;
    logic                sel_found, rsp_found, wb, rsp_hs;

    always_comb begin
        req_acc = req_val & ~occ_q;
        for (int i = 0; i < NREQ; i++) begin
            acc_nz[i]   = req_acc[i] & (req_cnt[i*T_LEN +: T_LEN] != '0);
            runnable[i] = occ_q[i] & ~done_q[i] & (rem_q[i] != '0);
        end
        others    = runnable & ~(NREQ'(1) << cur_q);
        drainable = occ_q & done_q;
    end

    // Descending scan so the candidate closest to the pointer wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_idx   = '0;
        rsp_found = 1'b0;
        rsp_sel   = '0;
        rsp_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sel_idx = rr_q + IDW'(k);
            if (runnable[sel_idx]) begin
                sel_found = 1'b1;
                sel_id    = sel_idx;
            end
            rsp_idx = rsp_ptr_q + IDW'(k);
            if (drainable[rsp_idx]) begin
                rsp_found = 1'b1;
                rsp_sel   = rsp_idx;
            end
        end
    end

    assign wb     = (state_q == S_WAIT) & core_out_val;
    assign rsp_hs = rsp_val_q & rsp_rdy;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rr_d         = rr_q;
        q_cnt_d      = q_cnt_q;
        busy_d       = busy_q;
        core_in_val  = 1'b0;
        core_out_rdy = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Fresh acceptances wake the FSM so the first operand issues two cycles later.
                if (|(runnable | acc_nz)) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (sel_found) begin
                    cur_d   = sel_id;
                    q_cnt_d = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                core_in_val = 1'b1;
                if (core_in_rdy) begin
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                core_out_rdy = 1'b1;
                if (core_out_val) begin
                    busy_d  = 1'b0;
                    q_cnt_d = q_cnt_q + QW'(1);
                    if (rem_q[cur_q] == T_LEN'(1)) begin
                        rr_d    = cur_q + IDW'(1);
                        state_d = S_IDLE;
                    end else if (q_cnt_q == Q_LAST && |others) begin
                        rr_d    = cur_q + IDW'(1);
                        state_d = S_SELECT;
                    end else if (q_cnt_q == Q_LAST) begin
                        q_cnt_d = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            rr_q    <= '0;
            q_cnt_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            q_cnt_q <= q_cnt_d;
            busy_q  <= busy_d;
        end
    end

    // A slot being written back is never done, and a draining slot is always done, so no overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            done_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                val_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_acc[i]) begin
                    occ_q[i]  <= 1'b1;
                    val_q[i]  <= req_dat[i*DAT_BITS +: DAT_BITS];
                    rem_q[i]  <= req_cnt[i*T_LEN +: T_LEN];
                    done_q[i] <= (req_cnt[i*T_LEN +: T_LEN] == '0);
                end else begin
                    if (wb && cur_q == IDW'(i)) begin
                        val_q[i] <= core_out_dat;
                        rem_q[i] <= rem_q[i] - T_LEN'(1);
                        if (rem_q[i] == T_LEN'(1)) done_q[i] <= 1'b1;
                    end
                    if (rsp_hs && rsp_id_q == IDW'(i)) begin
                        occ_q[i]  <= 1'b0;
                        done_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Reload only from an empty register so the slot just handed off is never picked twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_val_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_id_q  <= '0;
            rsp_ptr_q <= '0;
        end else if (rsp_hs) begin
            rsp_val_q <= 1'b0;
            rsp_ptr_q <= rsp_id_q + IDW'(1);
        end else if (!rsp_val_q && rsp_found) begin
            rsp_val_q <= 1'b1;
            rsp_id_q  <= rsp_sel;
            rsp_dat_q <= val_q[rsp_sel];
        end
    end

    assign req_rdy     = ~occ_q;
    assign core_in_dat = val_q[cur_q];
    assign rsp_val     = rsp_val_q;
    assign rsp_dat     = rsp_dat_q;
    assign rsp_id      = rsp_id_q;
    assign busy        = busy_q;
    assign cur_id      = cur_q;
endmodule

// File: tb/tb_msu_sched.sv
// Directed bench for msu_sched with a 3-cycle x^2 mod 1000003 core model and QUANTUM=4.
module tb_msu_sched;
    localparam int NREQ = 4;
    localparam int DB   = 64;
    localparam int TL   = 64;
    localparam logic [63:0] MODP = 64'd1000003;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_val;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ*DB-1:0] req_dat;
    logic [NREQ*TL-1:0] req_cnt;
    logic              core_in_val, core_in_rdy;
    logic [DB-1:0]     core_in_dat;
    logic              core_out_val, core_out_rdy;
    logic [DB-1:0]     core_out_dat;
    logic              rsp_val, rsp_rdy;
    logic [DB-1:0]     rsp_dat;
    logic [1:0]        rsp_id;
    logic              busy;
    logic [1:0]        cur_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_id[$];
    int hs_cyc[$];

    msu_sched #(.NREQ(NREQ), .DAT_BITS(DB), .T_LEN(TL), .QUANTUM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_dat(req_dat), .req_cnt(req_cnt),
        .core_in_val(core_in_val), .core_in_rdy(core_in_rdy), .core_in_dat(core_in_dat),
        .core_out_val(core_out_val), .core_out_rdy(core_out_rdy), .core_out_dat(core_out_dat),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_id(rsp_id),
        .busy(busy), .cur_id(cur_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Squaring core: one operand at a time, result valid three cycles after acceptance.
    logic        m_pend;
    int          m_cnt;
    logic [63:0] m_res;
    assign core_in_rdy  = ~m_pend;
    assign core_out_dat = m_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_cnt <= 0;
            m_res <= '0;
            core_out_val <= 1'b0;
        end else if (core_in_val && core_in_rdy) begin
            m_pend <= 1'b1;
            m_cnt <= 2;
            m_res <= (core_in_dat * core_in_dat) % MODP;
        end else if (m_pend && !core_out_val) begin
            if (m_cnt == 0) core_out_val <= 1'b1;
            else m_cnt <= m_cnt - 1;
        end else if (core_out_val && core_out_rdy) begin
            core_out_val <= 1'b0;
            m_pend <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && core_in_val && core_in_rdy) begin
            hs_id.push_back(int'(cur_id));
            hs_cyc.push_back(cyc);
        end
    end

    function automatic logic [63:0] sqn(input logic [63:0] x0, input int n);
        logic [63:0] x;
        x = x0;
        for (int i = 0; i < n; i++) x = (x * x) % MODP;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int s, input logic [63:0] v, input logic [63:0] c);
        req_dat[s*DB +: DB] = v;
        req_cnt[s*TL +: TL] = c;
        req_val[s] = 1'b1;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        for (int n = 0; n < budget && !rsp_val; n++) tick();
        chk({tag, "_rsp_val"}, rsp_val, 1);
    endtask

    task automatic pop(input string tag, input logic [63:0] dat, input int id);
        wait_rsp(tag, 3000);
        chk({tag, "_dat"}, rsp_dat, dat);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_rdy_held"}, req_rdy[id], 0);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk({tag, "_rdy_back"}, req_rdy[id], 1);
        chk({tag, "_rsp_drop"}, rsp_val, 0);
    endtask

    initial begin
        int run_id[6];
        int run_len[6];
        int exp_ids[$];
        int bad;

        rst_n = 1'b0;
        req_val = '0;
        req_dat = '0;
        req_cnt = '0;
        rsp_rdy = 1'b0;
        tick();
        tick();
        chk("rst_req_rdy", req_rdy, 4'hF);
        chk("rst_core_in_val", core_in_val, 0);
        chk("rst_core_out_rdy", core_out_rdy, 0);
        chk("rst_rsp_val", rsp_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_id", cur_id, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_req_rdy", req_rdy, 4'hF);
        chk("post_rst_rsp_dat", rsp_dat, 0);
        chk("post_rst_rsp_id", rsp_id, 0);

        // Two jobs preempting each other with QUANTUM=4.
        hs_id.delete();
        load(0, 64'd3, 64'd10);
        load(1, 64'd5, 64'd10);
        tick();
        req_val = '0;
        pop("q_slot0", sqn(64'd3, 10), 0);
        pop("q_slot1", sqn(64'd5, 10), 1);
        run_id  = '{0, 1, 0, 1, 0, 1};
        run_len = '{4, 4, 4, 4, 2, 2};
        exp_ids.delete();
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < run_len[r]; j++) exp_ids.push_back(run_id[r]);
        chk("q_hs_count", hs_id.size(), 20);
        for (int k = 0; k < 20; k++)
            chk($sformatf("q_hs_id%0d", k), (k < hs_id.size()) ? hs_id[k] : 99, exp_ids[k]);

        // Single job, latency and result.
        hs_id.delete();
        load(0, 64'd2, 64'd3);
        tick();
        req_val = '0;
        chk("t1_select_no_issue", core_in_val, 0);
        chk("t1_rdy_low", req_rdy[0], 0);
        tick();
        chk("t1_issue", core_in_val, 1);
        chk("t1_issue_dat", core_in_dat, 2);
        chk("t1_cur_id", cur_id, 0);
        tick();
        chk("t1_busy", busy, 1);
        pop("t1", 64'd256, 0);
        chk("t1_hs_count", hs_id.size(), 3);

        // Zero-count job bypasses the core.
        hs_id.delete();
        load(2, 64'd77, 64'd0);
        tick();
        req_val = '0;
        wait_rsp("t2_fast", 2);
        pop("t2", 64'd77, 2);
        chk("t2_no_core", hs_id.size(), 0);

        // Lone job crosses quantum boundaries without reselection gaps.
        hs_id.delete();
        hs_cyc.delete();
        load(3, 64'd11, 64'd9);
        tick();
        req_val = '0;
        pop("t3", sqn(64'd11, 9), 3);
        chk("t3_hs_count", hs_id.size(), 9);
        for (int k = 1; k < 9; k++) begin
            chk($sformatf("t3_id%0d", k), (k < hs_id.size()) ? hs_id[k] : 99, 3);
            chk($sformatf("t3_gap%0d", k),
                (k < hs_cyc.size()) ? hs_cyc[k] - hs_cyc[k-1] : 0, 5);
        end

        // Response backpressure.
        load(0, 64'd7, 64'd1);
        load(1, 64'd9, 64'd1);
        tick();
        req_val = '0;
        wait_rsp("bp_first", 200);
        bad = 0;
        for (int n = 0; n < 30; n++) begin
            if (rsp_val !== 1'b1 || rsp_id !== 2'd0 || rsp_dat !== 64'd49 || req_rdy[1:0] !== 2'b00)
                bad++;
            tick();
        end
        chk("bp_stable", bad, 0);
        pop("bp_slot0", 64'd49, 0);
        pop("bp_slot1", 64'd81, 1);

        // Reset mid-squaring.
        load(1, 64'd5, 64'd100);
        tick();
        req_val = '0;
        for (int n = 0; n < 50 && !busy; n++) tick();
        chk("rst_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_core_in_val", core_in_val, 0);
        chk("rst_mid_core_out_rdy", core_out_rdy, 0);
        chk("rst_mid_busy0", busy, 0);
        chk("rst_mid_cur_id", cur_id, 0);
        chk("rst_mid_req_rdy", req_rdy, 4'hF);
        chk("rst_mid_rsp_dat", rsp_dat, 0);
        chk("rst_mid_rsp_val", rsp_val, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rsp_val !== 1'b0 || core_in_val !== 1'b0 || req_rdy !== 4'hF) bad++;
        end
        chk("rst_mid_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
